// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing decoder: recovers pixel position, data enable and
// lock status from an active-low hsync/vsync pair. The geometry defaults to
// 640x480@60 and can be overridden through the parameters.
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_TOTAL    = 525,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] line_len
);

    localparam int unsigned GL_W = $clog2(LOCK_LINES + 1);

    localparam logic [15:0]     H_TO     = 16'(2 * H_TOTAL);
    localparam logic [15:0]     H_START  = 16'(H_SYNC + H_BP);
    localparam logic [15:0]     H_END    = 16'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [16:0]     H_LEN    = 17'(H_TOTAL);
    localparam logic [10:0]     V_START  = 11'(V_SYNC + V_BP);
    localparam logic [10:0]     V_END    = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0]     V_TO_PRE = 11'(2 * V_TOTAL - 1);
    localparam logic [11:0]     V_LEN    = 12'(V_TOTAL);
    localparam logic [GL_W-1:0] GL_FULL  = GL_W'(LOCK_LINES);

    // input synchronisers and edge detect
    logic hs_d1_q, hs_d2_q, vs_d1_q, vs_d2_q;
    logic hfall, vfall;

    // counter / measurement state
    logic [15:0]     h_cnt_q, h_cnt_d;
    logic [10:0]     v_cnt_q, v_cnt_d;
    logic [GL_W-1:0] good_q, good_d;
    logic            frame_ok_q, frame_ok_d;
    logic            h_arm_q, h_arm_d;
    logic            v_arm_q, v_arm_d;
    logic [15:0]     line_len_q, line_len_d;
    logic [16:0]     h_plus1;
    logic [11:0]     v_plus1;

    // output stage
    logic       h_err_q, h_err_d, v_err_q, v_err_d;
    logic       locked_q, lock_d;
    logic       de_q, de_d, h_win, v_win;
    logic [9:0] x_q, x_d, y_q, y_d;

    assign hfall = hs_d2_q & ~hs_d1_q;
    assign vfall = vs_d2_q & ~vs_d1_q;

    // two-stage capture of the sync inputs, idle high out of reset
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1_q <= 1'b1;
            hs_d2_q <= 1'b1;
            vs_d1_q <= 1'b1;
            vs_d2_q <= 1'b1;
        end else begin
            hs_d1_q <= hsync_in;
            hs_d2_q <= hs_d1_q;
            vs_d1_q <= vsync_in;
            vs_d2_q <= vs_d1_q;
        end
    end

    // horizontal counter, line-length measurement and hsync timeout
    always_comb begin
        h_plus1    = {1'b0, h_cnt_q} + 17'd1;
        h_cnt_d    = (h_cnt_q == 16'hFFFF) ? h_cnt_q : h_plus1[15:0];
        good_d     = good_q;
        h_arm_d    = h_arm_q;
        line_len_d = line_len_q;
        h_err_d    = 1'b0;
        if (hfall) begin
            h_cnt_d = '0;
            if (!h_arm_q) begin
                h_arm_d = 1'b1;
            end else begin
                line_len_d = h_plus1[15:0];
                if (h_plus1 == H_LEN) begin
                    if (good_q != GL_FULL) good_d = good_q + 1'b1;
                end else begin
                    good_d  = '0;
                    h_err_d = 1'b1;
                end
            end
        end else if (h_cnt_q == H_TO) begin
            // h_cnt passes this value only once per missing hfall
            good_d  = '0;
            h_err_d = 1'b1;
        end
    end

    // vertical counter, frame-length measurement and vsync timeout
    always_comb begin
        v_plus1    = {1'b0, v_cnt_q} + 12'd1;
        v_cnt_d    = v_cnt_q;
        frame_ok_d = frame_ok_q;
        v_arm_d    = v_arm_q;
        v_err_d    = 1'b0;
        if (vfall) begin
            v_cnt_d = '0;
            if (!v_arm_q) begin
                v_arm_d = 1'b1;
            end else if (v_plus1 == V_LEN) begin
                frame_ok_d = 1'b1;
            end else begin
                frame_ok_d = 1'b0;
                v_err_d    = 1'b1;
            end
        end else if (hfall) begin
            if (v_cnt_q != 11'h7FF) v_cnt_d = v_plus1[10:0];
            // v_cnt holds its value for a whole line, so the timeout is
            // flagged on the increment that reaches it, giving one pulse
            if (v_cnt_q == V_TO_PRE) begin
                frame_ok_d = 1'b0;
                v_err_d    = 1'b1;
            end
        end
    end

    // window decode from the current counter state
    always_comb begin
        lock_d = (good_q == GL_FULL) && frame_ok_q;
        h_win  = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
        v_win  = (v_cnt_q >= V_START) && (v_cnt_q < V_END);
        de_d   = h_win && v_win && lock_d;
        x_d    = '0;
        y_d    = '0;
        if (de_d) begin
            x_d = 10'(h_cnt_q - H_START);
            y_d = 10'(v_cnt_q - V_START);
        end
    end

    // counter and measurement registers
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            good_q     <= '0;
            frame_ok_q <= 1'b0;
            h_arm_q    <= 1'b0;
            v_arm_q    <= 1'b0;
            line_len_q <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            good_q     <= good_d;
            frame_ok_q <= frame_ok_d;
            h_arm_q    <= h_arm_d;
            v_arm_q    <= v_arm_d;
            line_len_q <= line_len_d;
        end
    end

    // registered outputs, one clock behind the counter state
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
            h_err_q  <= 1'b0;
            v_err_q  <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            de_q     <= de_d;
            locked_q <= lock_d;
            h_err_q  <= h_err_d;
            v_err_q  <= v_err_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign de       = de_q;
    assign locked   = locked_q;
    assign h_err    = h_err_q;
    assign v_err    = v_err_q;
    assign line_len = line_len_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a reduced geometry (80 clocks x 30 lines)
// so that many frames fit in a short run. Segments of lines are described in
// a table; hand-written sequences cover timeout and mid-line reset.
module tb_vga_sync_decoder;

    localparam int HT = 80;
    localparam int HS = 8;
    localparam int HB = 8;
    localparam int HA = 60;
    localparam int VT = 30;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 24;
    localparam int LL = 4;

    logic        clk_25MHz = 1'b0;
    logic        rst_n;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        locked;
    logic        h_err;
    logic        v_err;
    logic [15:0] line_len;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_LINES(LL)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .de(de), .locked(locked),
        .h_err(h_err), .v_err(v_err), .line_len(line_len)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fline = 0;
    int fall_cyc = 0;

    always @(posedge clk_25MHz) cyc <= cyc + 1;

    // per-segment monitor, cleared whenever seg_id changes
    int seg_id = 0;
    int mon_seg = 0;
    int m_herr, m_verr, m_de, m_inv, m_herr_cyc;
    int m_fx, m_fy, m_lx, m_ly;
    bit m_seen;
    bit prev_de = 1'b0;
    logic [9:0] prev_x = '0;

    always @(negedge clk_25MHz) begin
        if (seg_id != mon_seg) begin
            mon_seg = seg_id;
            m_herr = 0; m_verr = 0; m_de = 0; m_inv = 0; m_herr_cyc = 0;
            m_fx = 0; m_fy = 0; m_lx = 0; m_ly = 0; m_seen = 1'b0;
        end
        if (rst_n) begin
            if (h_err) begin m_herr++; m_herr_cyc = cyc; end
            if (v_err) m_verr++;
            if (de) begin
                m_de++;
                if (!m_seen) begin m_fx = int'(x); m_fy = int'(y); m_seen = 1'b1; end
                m_lx = int'(x);
                m_ly = int'(y);
                if (prev_de && x != prev_x + 10'd1) m_inv++;
                if (!locked) m_inv++;
            end else if (x != 10'd0 || y != 10'd0) begin
                m_inv++;
            end
        end
        prev_de = de;
        prev_x  = x;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25MHz);
            #1;
        end
    endtask

    // one line: hsync low for HS clocks; vsync low on the first VS lines
    task automatic send_line(input int len);
        hsync_in = 1'b0;
        vsync_in = (fline < VS) ? 1'b0 : 1'b1;
        fall_cyc = cyc;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk_25MHz);
            #1;
            if (i == HS) hsync_in = 1'b1;
        end
        fline++;
    endtask

    task automatic send_lines(input int n, input int len, input bit new_frame);
        if (new_frame) fline = 0;
        for (int i = 0; i < n; i++) send_line(len);
    endtask

    typedef struct {
        int nlines;
        int len;
        bit nf;
        int herr;
        int verr;
        int ll;
        bit lock;
        int de_n;
        bit cxy;
        int fx, fy, lx, ly;
    } seg_t;

    seg_t segs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                nl  len   nf herr verr ll    lock de       cxy fx fy lx    ly
        segs[0] = '{30, HT,   1, 0, 0, HT,   0, 0,       0, 0, 0, 0,    0};
        segs[1] = '{30, HT,   1, 0, 0, HT,   1, HA*VA,   1, 0, 0, HA-1, VA-1};
        segs[2] = '{6,  HT,   1, 0, 0, HT,   1, HA,      1, 0, 0, HA-1, 0};
        segs[3] = '{1,  HT-1, 0, 0, 0, HT,   1, HA,      1, 0, 1, HA-1, 1};
        segs[4] = '{1,  HT,   0, 1, 0, HT-1, 0, 0,       0, 0, 0, 0,    0};
        segs[5] = '{4,  HT,   0, 0, 0, HT,   1, HA,      1, 0, 6, HA-1, 6};
        segs[6] = '{18, HT,   0, 0, 0, HT,   1, 17*HA,   1, 0, 7, HA-1, VA-1};
        segs[7] = '{29, HT,   1, 0, 0, HT,   1, HA*VA,   1, 0, 0, HA-1, VA-1};
        segs[8] = '{30, HT,   1, 0, 1, HT,   0, 0,       0, 0, 0, 0,    0};
        segs[9] = '{30, HT,   1, 0, 0, HT,   1, HA*VA,   1, 0, 0, HA-1, VA-1};

        rst_n = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        tick(3);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_h_err", h_err, 0);
        chk("rst_v_err", v_err, 0);
        chk("rst_line_len", line_len, 0);
        rst_n = 1'b1;
        tick(5);

        for (int s = 0; s < 10; s++) begin
            seg_id++;
            send_lines(segs[s].nlines, segs[s].len, segs[s].nf);
            chk($sformatf("seg%0d_h_err", s), m_herr, segs[s].herr);
            chk($sformatf("seg%0d_v_err", s), m_verr, segs[s].verr);
            chk($sformatf("seg%0d_line_len", s), line_len, segs[s].ll);
            chk($sformatf("seg%0d_locked", s), locked, segs[s].lock);
            chk($sformatf("seg%0d_de_count", s), m_de, segs[s].de_n);
            chk($sformatf("seg%0d_invariants", s), m_inv, 0);
            if (segs[s].cxy) begin
                chk($sformatf("seg%0d_first_x", s), m_fx, segs[s].fx);
                chk($sformatf("seg%0d_first_y", s), m_fy, segs[s].fy);
                chk($sformatf("seg%0d_last_x", s), m_lx, segs[s].lx);
                chk($sformatf("seg%0d_last_y", s), m_ly, segs[s].ly);
            end
        end

        // hsync stops: one h_err at h_cnt == 2*HT, visible 2*HT+3 clocks
        // after the edge that first saw the last falling hsync
        seg_id++;
        tick(400);
        chk("timeout_h_err_count", m_herr, 1);
        chk("timeout_h_err_delay", m_herr_cyc - fall_cyc, 2*HT + 3);
        chk("timeout_locked", locked, 0);
        chk("timeout_v_err_count", m_verr, 0);

        // resume: first line is overlong, frame length still correct
        seg_id++;
        send_lines(10, HT, 1'b1);
        chk("resume_h_err_count", m_herr, 1);
        chk("resume_v_err_count", m_verr, 0);
        chk("resume_locked", locked, 1);

        // start line 10 (active row 5) and stop 30 clocks in
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk_25MHz);
            #1;
            if (i == HS) hsync_in = 1'b1;
        end
        chk("midline_de", de, 1);
        chk("midline_x", x, 11);
        chk("midline_y", y, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_x", x, 0);
        chk("async_rst_y", y, 0);
        chk("async_rst_de", de, 0);
        chk("async_rst_locked", locked, 0);
        chk("async_rst_line_len", line_len, 0);
        chk("async_rst_h_err", h_err, 0);
        chk("async_rst_v_err", v_err, 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // first hfall/vfall after reset only arm
        seg_id++;
        send_lines(10, HT, 1'b1);
        chk("rearm_h_err_count", m_herr, 0);
        chk("rearm_v_err_count", m_verr, 0);
        chk("rearm_locked", locked, 0);
        chk("rearm_line_len", line_len, HT);
        send_lines(20, HT, 1'b0);
        chk("rearm_locked_before_2nd_vfall", locked, 0);
        send_lines(2, HT, 1'b1);
        chk("relock_locked", locked, 1);
        chk("relock_v_err_count", m_verr, 0);
        chk("relock_h_err_count", m_herr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
